// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 64-bit ALU.
// One operation is in flight at a time: accept in IDLE, capture in EXEC, hold in RESP.
module alu_arbiter (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][2:0]     req_funct,
    input  logic [1:0][63:0]    req_a,
    input  logic [1:0][63:0]    req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [63:0]         rsp_result,
    output logic [5:0]          rsp_flags,
    output logic [2:0]          alu_funct,
    output logic signed [63:0]  alu_a,
    output logic signed [63:0]  alu_b,
    input  logic [63:0]         alu_result,
    input  logic [5:0]          alu_flags,
    output logic                busy,
    output logic [31:0]         ops_done
);

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                    state;
    logic                      last_id;
    logic [1:0]                grant;
    logic                      sel;
    logic [2:0]                op_funct_p0;
    logic signed [DATA_W-1:0]  op_a_p0;
    logic signed [DATA_W-1:0]  op_b_p0;
    logic                      op_id_p0;
    logic                      rsp_vld_p1;

    // Round-robin: on contention the requester that did not finish last wins.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_id ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign sel       = grant[1];
    assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
    assign rsp_valid = rsp_vld_p1 & ~reset;
    assign busy      = (state != IDLE);
    assign alu_funct = op_funct_p0;
    assign alu_a     = op_a_p0;
    assign alu_b     = op_b_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            rsp_vld_p1  <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_id      <= 1'b0;
            op_funct_p0 <= '0;
            op_a_p0     <= '0;
            op_b_p0     <= '0;
            op_id_p0    <= 1'b0;
            ops_done    <= '0;
        end else begin
            unique case (state)
                // p0: operation registers feed the ALU until the next accept
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        op_funct_p0 <= req_funct[sel];
                        op_a_p0     <= $signed(req_a[sel]);
                        op_b_p0     <= $signed(req_b[sel]);
                        op_id_p0    <= sel;
                        state       <= EXEC;
                    end
                end
                // p1: ALU output captured and held for the consumer
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_id     <= op_id_p0;
                    rsp_vld_p1 <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_vld_p1 <= 1'b0;
                        last_id    <= rsp_id;
                        ops_done   <= ops_done + 32'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural 64-bit ALU on the alu_* ports and a
// transaction-level reference model for grants, latency and results.
module tb_alu_arbiter;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0][2:0]   req_funct = '0;
    logic [1:0][63:0]  req_a = '0;
    logic [1:0][63:0]  req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [63:0]       rsp_result;
    logic [5:0]        rsp_flags;
    logic [2:0]        alu_funct;
    logic [63:0]       alu_a;
    logic [63:0]       alu_b;
    logic [63:0]       alu_result;
    logic [5:0]        alu_flags;
    logic              busy;
    logic [31:0]       ops_done;

    int          errors = 0;
    int          checks = 0;
    logic        m_last;
    logic [31:0] m_ops;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .ops_done(ops_done)
    );

    // Shared ALU stand-in
    logic alu_ovf;
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_funct)
            3'd0: alu_result = alu_a;
            3'd1: begin
                alu_result = alu_a + alu_b;
                alu_ovf = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'd2: begin
                alu_result = alu_a - alu_b;
                alu_ovf = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: begin
                alu_result = alu_a + 64'd1;
                alu_ovf = (alu_a == 64'h7FFF_FFFF_FFFF_FFFF);
            end
            default: alu_result = '0;
        endcase
        alu_flags = {alu_ovf, alu_result[63], alu_result == 64'd0, alu_a == alu_b,
                     $signed(alu_a) > $signed(alu_b), $signed(alu_a) < $signed(alu_b)};
    end

    // Reference: exact arithmetic in 65 bits, overflow when the value leaves the 64-bit range
    function automatic void ref_alu(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [5:0] fl);
        logic signed [64:0] wa, wb, w;
        logic ovf;
        wa = $signed({a[63], a});
        wb = $signed({b[63], b});
        w  = '0;
        r  = '0;
        case (f)
            3'd0: r = a;
            3'd1: w = wa + wb;
            3'd2: w = wa - wb;
            3'd3: r = a & b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: w = wa + 65'sd1;
            default: r = '0;
        endcase
        ovf = 1'b0;
        if (f == 3'd1 || f == 3'd2 || f == 3'd6) begin
            r   = w[63:0];
            ovf = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (w < -65'sh0_8000_0000_0000_0000);
        end
        fl = {ovf, r[63], r == 64'd0, a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return '1;
            3: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic apply_reset(input logic [1:0] v);
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = v;
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1'b1;
        m_ops = '0;
    endtask

    // Returns at the negedge of the accept cycle
    task automatic issue(input bit id, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, output bit ok);
        @(posedge clk); #1;
        req_valid = id ? 2'b10 : 2'b01;
        req_funct[id] = f;
        req_a[id] = a;
        req_b[id] = b;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 2'b00;
        m_last = 1'b1;
        m_ops = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ops_done !== 32'd0) begin errors++; $display("FAIL reset_ops: got %0d expected 0", ops_done); end
        checks++; if (rsp_result !== 64'd0 || rsp_flags !== 6'd0 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got %h/%b/%b expected 0/0/0", rsp_result, rsp_flags, rsp_id); end
        checks++; if (alu_funct !== 3'd0 || alu_a !== 64'd0 || alu_b !== 64'd0) begin
            errors++; $display("FAIL reset_alu: got %0d/%h/%h expected 0/0/0", alu_funct, alu_a, alu_b); end
    endtask

    task automatic test_basic_sum();
        bit ok;
        logic [63:0] er;
        logic [5:0] ef;
        apply_reset(2'b00);
        rsp_ready = 1'b1;
        issue(1'b0, 3'd1, 64'd5, 64'd7, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sum_accept: got none expected accept"); end
        ref_alu(3'd1, 64'd5, 64'd7, er, ef);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL sum_exec: got valid=%b busy=%b expected 0/1", rsp_valid, busy); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL sum_rsp: got valid=%b id=%b expected 1/0", rsp_valid, rsp_id); end
        checks++; if (rsp_result !== 64'd12) begin errors++; $display("FAIL sum_result: got %0d expected 12", rsp_result); end
        checks++; if (rsp_flags !== ef || rsp_flags[0] !== 1'b1 || rsp_flags[3] !== 1'b0 || rsp_flags[5] !== 1'b0) begin
            errors++; $display("FAIL sum_flags: got %b expected %b", rsp_flags, ef); end
        @(negedge clk);
        checks++; if (ops_done !== 32'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL sum_done: got ops=%0d busy=%b expected 1/0", ops_done, busy); end
    endtask

    task automatic test_round_robin();
        int grants[4];
        int n;
        logic prev;
        apply_reset(2'b11);
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) grants[i] = 2;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL rr_both: got 11 expected one-hot or 00"); end
            if (|req_ready) begin
                grants[n] = req_ready[1] ? 1 : 0;
                n++;
            end
            @(posedge clk); #1;
        end
        prev = m_last;
        for (int i = 0; i < 4; i++) begin
            prev = ~prev;
            checks++; if (grants[i] != int'(prev)) begin
                errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], prev); end
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [63:0] a, b, er, r0;
        logic [5:0] ef, f0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        ref_alu(3'd2, a, b, er, ef);
        rsp_ready = 1'b0;
        issue(1'b1, 3'd2, a, b, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got none expected accept"); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_flags !== ef || rsp_id !== 1'b1) begin
            errors++; $display("FAIL bp_first: got %b %h %b %b expected 1 %h %b 1", rsp_valid, rsp_result, rsp_flags, rsp_id, er, ef); end
        r0 = rsp_result;
        f0 = rsp_flags;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== r0 || rsp_flags !== f0 || rsp_id !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d: got %b %h %b %b expected 1 %h %b 1", k, rsp_valid, rsp_result, rsp_flags, rsp_id, r0, f0); end
            checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_ready%0d: got ready=%b busy=%b expected 00/1", k, req_ready, busy); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got busy=%b valid=%b expected 0/0", busy, rsp_valid); end
    endtask

    task automatic test_edges();
        bit ok;
        apply_reset(2'b00);
        rsp_ready = 1'b1;
        issue(1'b1, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_accept: got none expected accept"); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_result !== 64'h8000_0000_0000_0000 || rsp_id !== 1'b1) begin
            errors++; $display("FAIL ovf_result: got %h id=%b expected 8000000000000000 id=1", rsp_result, rsp_id); end
        checks++; if (rsp_flags[5] !== 1'b1 || rsp_flags[4] !== 1'b1) begin
            errors++; $display("FAIL ovf_flags: got %b expected ovf=1 neg=1", rsp_flags); end
        issue(1'b0, 3'd7, 64'h1234, 64'h5678, ok);
        checks++; if (!ok) begin errors++; $display("FAIL f7_accept: got none expected accept"); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (alu_funct !== 3'd7) begin errors++; $display("FAIL f7_funct: got %0d expected 7", alu_funct); end
        @(negedge clk);
        checks++; if (rsp_result !== 64'd0) begin errors++; $display("FAIL f7_result: got %h expected 0", rsp_result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset(2'b00);
        rsp_ready = 1'b1;
        issue(1'b1, 3'd4, {$urandom, $urandom}, {$urandom, $urandom}, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_accept: got none expected accept"); end
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = 2'b11;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'd0) begin
            errors++; $display("FAIL mid_state: got valid=%b busy=%b ops=%0d expected 0/0/0", rsp_valid, busy, ops_done); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit          inflight;
        int          age;
        int          gi;
        logic        exp_id;
        logic [63:0] exp_r;
        logic [5:0]  exp_f;
        logic [1:0]  exp_rdy;
        logic        exp_vld;
        apply_reset(2'b00);
        inflight = 1'b0;
        age = 0;
        exp_id = 1'b0;
        exp_r = '0;
        exp_f = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                req_funct[i] = 3'($urandom_range(0, 7));
                req_a[i] = pick();
                req_b[i] = pick();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (inflight) age++;
            if (inflight) exp_rdy = 2'b00;
            else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
            else exp_rdy = req_valid;
            exp_vld = inflight && age >= 2;
            checks++; if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
            checks++; if (rsp_valid !== exp_vld || busy !== inflight) begin
                errors++; $display("FAIL rnd_valid c%0d: got valid=%b busy=%b expected %b/%b", cyc, rsp_valid, busy, exp_vld, inflight); end
            checks++; if (ops_done !== m_ops) begin
                errors++; $display("FAIL rnd_ops c%0d: got %0d expected %0d", cyc, ops_done, m_ops); end
            if (exp_vld) begin
                checks++; if (rsp_id !== exp_id || rsp_result !== exp_r || rsp_flags !== exp_f) begin
                    errors++; $display("FAIL rnd_rsp c%0d: got %b %h %b expected %b %h %b", cyc, rsp_id, rsp_result, rsp_flags, exp_id, exp_r, exp_f); end
            end
            if (exp_vld && rsp_ready) begin
                inflight = 1'b0;
                m_last = exp_id;
                m_ops++;
            end else if (!inflight && exp_rdy != 2'b00) begin
                gi = exp_rdy[1] ? 1 : 0;
                ref_alu(req_funct[gi], req_a[gi], req_b[gi], exp_r, exp_f);
                exp_id = exp_rdy[1];
                inflight = 1'b1;
                age = 0;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_round_robin();
        test_backpressure();
        test_edges();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
